// File: rtl/multicycle_control_fsm.sv
// Main control sequencer for a multicycle RV32I core: steps the shared datapath
// through fetch/decode/execute/memory/writeback and stalls on the memory handshake.
module multicycle_control_fsm #(
   parameter logic [3:0] RESET_STATE = 4'd0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instr,
   input  logic        zero,
   input  logic        alu_lsb,
   input  logic        mem_ready,
   output logic        pc_write,
   output logic        ir_write,
   output logic        adr_src,
   output logic        mem_read,
   output logic        mem_write,
   output logic        reg_write,
   output logic [1:0]  alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  result_src,
   output logic [3:0]  alu_ctrl,
   output logic [2:0]  imm_ctrl,
   output logic        illegal,
   output logic [3:0]  state_o
);

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADR   = 4'd2,
      S_MEM_RD    = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WR    = 4'd5,
      S_EXEC_R    = 4'd6,
      S_EXEC_I    = 4'd7,
      S_ALU_WB    = 4'd8,
      S_BRANCH    = 4'd9,
      S_JAL       = 4'd10,
      S_EXEC_JALR = 4'd11,
      S_JALR      = 4'd12,
      S_LUI       = 4'd13,
      S_TRAP      = 4'd14
   } state_t;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SLT  = 4'd5;
   localparam logic [3:0] ALU_SLTU = 4'd6;
   localparam logic [3:0] ALU_SLL  = 4'd7;
   localparam logic [3:0] ALU_SRL  = 4'd8;
   localparam logic [3:0] ALU_SRA  = 4'd9;

   state_t      r_state;
   logic [6:0]  w_opcode;
   logic [2:0]  w_funct3;
   logic        w_f7b5;

   assign w_opcode = instr[6:0];
   assign w_funct3 = instr[14:12];
   assign w_f7b5   = instr[30];
   assign state_o  = r_state;

   // funct7b5 only selects SUB for register-register ops; shifts honour it in both forms
   function automatic logic [3:0] f_exec_op(input logic [2:0] f3, input logic b5, input logic is_r);
      logic [3:0] op;
      case (f3)
         3'b000:  op = (is_r && b5) ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = b5 ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         3'b111:  op = ALU_AND;
         default: op = ALU_ADD;
      endcase
      return op;
   endfunction

   function automatic logic [3:0] f_branch_op(input logic [2:0] f3);
      logic [3:0] op;
      case (f3)
         3'b000, 3'b001: op = ALU_SUB;
         3'b100, 3'b101: op = ALU_SLT;
         3'b110, 3'b111: op = ALU_SLTU;
         default:        op = ALU_ADD;
      endcase
      return op;
   endfunction

   function automatic logic f_branch_taken(input logic [2:0] f3, input logic z, input logic lsb);
      logic t;
      case (f3)
         3'b000:         t = z;
         3'b001:         t = ~z;
         3'b100, 3'b110: t = lsb;
         3'b101, 3'b111: t = ~lsb;
         default:        t = 1'b0;
      endcase
      return t;
   endfunction

   // State register and next-state sequencing
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= state_t'(RESET_STATE);
      end else begin
         case (r_state)
            S_FETCH:     r_state <= mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
               case (w_opcode)
                  OP_LOAD, OP_STORE: r_state <= S_MEM_ADR;
                  OP_R:              r_state <= S_EXEC_R;
                  OP_I:              r_state <= S_EXEC_I;
                  OP_BR:             r_state <= S_BRANCH;
                  OP_JAL:            r_state <= S_JAL;
                  OP_JALR:           r_state <= S_EXEC_JALR;
                  OP_LUI:            r_state <= S_LUI;
                  OP_AUIPC:          r_state <= S_ALU_WB;
                  default:           r_state <= S_TRAP;
               endcase
            end
            S_MEM_ADR:   r_state <= (w_opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:    r_state <= mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WB:    r_state <= S_FETCH;
            S_MEM_WR:    r_state <= mem_ready ? S_FETCH : S_MEM_WR;
            S_EXEC_R:    r_state <= S_ALU_WB;
            S_EXEC_I:    r_state <= S_ALU_WB;
            S_ALU_WB:    r_state <= S_FETCH;
            S_BRANCH:    r_state <= S_FETCH;
            S_JAL:       r_state <= S_ALU_WB;
            S_EXEC_JALR: r_state <= S_JALR;
            S_JALR:      r_state <= S_ALU_WB;
            S_LUI:       r_state <= S_FETCH;
            S_TRAP:      r_state <= S_TRAP;
            default:     r_state <= S_FETCH;
         endcase
      end
   end

   // Immediate format follows the opcode in every state
   always_comb begin
      case (w_opcode)
         OP_LOAD, OP_I, OP_JALR: imm_ctrl = 3'd0;
         OP_STORE:               imm_ctrl = 3'd1;
         OP_BR:                  imm_ctrl = 3'd2;
         OP_LUI, OP_AUIPC:       imm_ctrl = 3'd3;
         OP_JAL:                 imm_ctrl = 3'd4;
         default:                imm_ctrl = 3'd0;
      endcase
   end

   // Datapath controls; everything is held quiet while reset is asserted
   always_comb begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      adr_src    = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      result_src = 2'b00;
      alu_ctrl   = ALU_ADD;
      illegal    = 1'b0;
      if (reset) begin
         illegal = 1'b0;
      end else begin
         case (r_state)
            S_FETCH: begin
               mem_read = 1'b1;
               if (mem_ready) begin
                  ir_write   = 1'b1;
                  pc_write   = 1'b1;
                  alu_src_b  = 2'b10;
                  result_src = 2'b10;
               end else begin
                  ir_write = 1'b0;
               end
            end
            S_DECODE: begin
               alu_src_a = 2'b01;
               alu_src_b = 2'b01;
            end
            S_MEM_ADR, S_EXEC_JALR: begin
               alu_src_a = 2'b10;
               alu_src_b = 2'b01;
            end
            S_MEM_RD: begin
               mem_read = 1'b1;
               adr_src  = 1'b1;
            end
            S_MEM_WB: begin
               reg_write  = 1'b1;
               result_src = 2'b01;
            end
            S_MEM_WR: begin
               mem_write = 1'b1;
               adr_src   = 1'b1;
            end
            S_EXEC_R: begin
               alu_src_a = 2'b10;
               alu_ctrl  = f_exec_op(w_funct3, w_f7b5, 1'b1);
            end
            S_EXEC_I: begin
               alu_src_a = 2'b10;
               alu_src_b = 2'b01;
               alu_ctrl  = f_exec_op(w_funct3, w_f7b5, 1'b0);
            end
            S_ALU_WB: reg_write = 1'b1;
            S_BRANCH: begin
               alu_src_a = 2'b10;
               alu_ctrl  = f_branch_op(w_funct3);
               pc_write  = f_branch_taken(w_funct3, zero, alu_lsb);
            end
            S_JAL, S_JALR: begin
               pc_write  = 1'b1;
               alu_src_a = 2'b01;
               alu_src_b = 2'b10;
            end
            S_LUI: begin
               reg_write  = 1'b1;
               result_src = 2'b11;
            end
            S_TRAP:  illegal = 1'b1;
            default: illegal = 1'b0;
         endcase
      end
   end

endmodule
